// File: rtl/inv_issue_ctrl.sv
// Issue controller for the modular inversion core: buffers operands in a FIFO,
// runs one core job at a time, and hands each result downstream via valid/ready.
module inv_issue_ctrl #(
    parameter int DATA_W      = 255,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_core_first,
    output logic [DATA_W-1:0] o_core_a,
    input  logic [DATA_W-1:0] i_core_inv,
    input  logic              i_core_valid,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic [1:0]        o_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic              head_zero;

    logic              out_full;
    logic [DATA_W-1:0] out_data;
    logic              accept;
    logic [CNT_W-1:0]  wdog;
    logic              timeout;
    logic              core_capture;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign head_zero  = (head == '0);

    assign o_in_ready = i_rst_n & ~fifo_full;
    assign push       = i_in_valid & o_in_ready;
    assign accept     = out_full & i_out_ready;
    assign timeout    = (state == WAIT) && (wdog == CNT_W'(TIMEOUT_CYC - 1));
    assign core_capture = (state == WAIT) && i_core_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty && !out_full && !head_zero) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            // A result arriving on the timeout cycle still counts as a completion.
            WAIT: begin
                if (i_core_valid)  state_nxt = HOLD;
                else if (timeout)  state_nxt = IDLE;
            end
            HOLD:  if (i_out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_core_first = (state == ISSUE);
        pop          = (state == IDLE) && !fifo_empty && !out_full;
        o_out_valid  = out_full;
        o_out_data   = out_data;
        o_busy       = (state != IDLE) || !fifo_empty || out_full;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            o_core_a <= '0;
            wdog     <= '0;
            out_full <= 1'b0;
            out_data <= '0;
            o_err    <= 2'b00;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

            if (pop && !head_zero) o_core_a <= head;

            if (state == ISSUE)     wdog <= '0;
            else if (state == WAIT) wdog <= wdog + CNT_W'(1);

            // Zero operands skip the core and land directly in the output slot.
            if (core_capture) begin
                out_full <= 1'b1;
                out_data <= i_core_inv;
            end else if (pop && head_zero) begin
                out_full <= 1'b1;
                out_data <= '0;
            end else if (accept) begin
                out_full <= 1'b0;
                out_data <= '0;
            end

            if (i_core_valid && (state != WAIT)) o_err[0] <= 1'b1;
            if (timeout && !i_core_valid)        o_err[1] <= 1'b1;
        end
    end
endmodule
